// File: rtl/mms_line_fill_rsp.sv
// mms_line_fill_rsp: critical-word-first 4-word line fill, one memory read outstanding
module mms_line_fill_rsp #(
   parameter int ADDR_WD = 32,
   parameter int DATA_WD = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [ADDR_WD-1:0]   req_addr_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [4*DATA_WD-1:0] rsp_line_o,
   output logic [ADDR_WD-1:0]   rsp_addr_o,
   output logic                 mem_req_valid_o,
   input  logic                 mem_req_ready_i,
   output logic [ADDR_WD-1:0]   mem_addr_o,
   input  logic                 mem_rsp_valid_i,
   input  logic [DATA_WD-1:0]   mem_rdata_i
);
   typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_e;
   state_e                  state_q, state_d;
   logic [ADDR_WD-5:0]      base_q, base_d;
   logic [1:0]              start_q, start_d, cnt_q, cnt_d, widx;
   logic [3:0][DATA_WD-1:0] line_q, line_d;
   logic                    unused_addr_bits;
   assign unused_addr_bits = ^req_addr_i[1:0];
   assign widx            = start_q + cnt_q;
   assign req_ready_o     = state_q == IDLE;
   assign mem_req_valid_o = state_q == MREQ;
   assign rsp_valid_o     = state_q == RESP;
   assign mem_addr_o      = {base_q, widx, 2'b00};
   assign rsp_addr_o      = {base_q, 4'b0000};
   assign rsp_line_o      = line_q;
   // next state: capture request, walk words from the critical one, store by word index
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      start_d = start_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      case (state_q)
         IDLE: if (req_valid_i) begin
            base_d  = req_addr_i[ADDR_WD-1:4];
            start_d = req_addr_i[3:2];
            cnt_d   = 2'd0;
            state_d = MREQ;
         end
         MREQ: state_d = mem_req_ready_i ? MWAIT : MREQ;
         MWAIT: if (mem_rsp_valid_i) begin
            line_d[widx] = mem_rdata_i;
            cnt_d        = cnt_q == 2'd3 ? cnt_q : cnt_q + 2'd1;
            state_d      = cnt_q == 2'd3 ? RESP : MREQ;
         end
         RESP: state_d = rsp_ready_i ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   // state registers, cleared asynchronously so a fill in progress is abandoned
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         start_q <= '0;
         cnt_q   <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         start_q <= start_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
      end
   end
endmodule

// File: tb/tb_mms_line_fill_rsp.sv
// tb_mms_line_fill_rsp: random and directed line fills against a word-level model
module tb_mms_line_fill_rsp;
   logic         clk = 1'b0, rst_n = 1'b0;
   logic         req_valid = 1'b0, rsp_ready = 1'b0;
   logic [31:0]  req_addr = '0;
   logic         mem_req_ready, mem_rsp_valid;
   logic [31:0]  mem_rdata;
   logic         req_ready, rsp_valid, mem_req_valid;
   logic [127:0] rsp_line;
   logic [31:0]  rsp_addr, mem_addr;
   int checks = 0, failures = 0;
   int rdy_low[4], dly[4];
   int reqn = 0;
   logic [31:0] salt = '0;
   bit spur_en = 1'b0;
   bit busy = 1'b0;
   logic [31:0]  exp_q[$], addr_log[$];
   logic [127:0] exp_line = '0, last_line = '0;
   logic [31:0]  exp_raddr = '0, last_raddr = '0;

   always #5 clk = ~clk;

   mms_line_fill_rsp dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_line_o(rsp_line), .rsp_addr_o(rsp_addr),
      .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_addr_o(mem_addr),
      .mem_rsp_valid_i(mem_rsp_valid), .mem_rdata_i(mem_rdata)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // memory agent: per-request ready stalls and data delays, optional stray responses
   initial begin
      int lowleft, pend, cur, hsdly;
      bit in_req, hs;
      logic [31:0] paddr, hsaddr;
      lowleft = 0; pend = 0; cur = 0; hsdly = 1; in_req = 0; hs = 0; paddr = '0; hsaddr = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         if (hs) begin pend = hsdly; paddr = hsaddr; hs = 0; end
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin mem_rsp_valid = 1'b1; mem_rdata = paddr ^ salt; end
         end else if (spur_en && $urandom_range(0, 3) == 0) begin
            mem_rsp_valid = 1'b1; mem_rdata = $urandom;
         end
         if (mem_req_valid) begin
            if (!in_req) begin in_req = 1; cur = reqn; lowleft = rdy_low[reqn % 4]; reqn++; end
            if (lowleft > 0) begin mem_req_ready = 1'b0; lowleft--; end
            else mem_req_ready = 1'b1;
            if (mem_req_ready) begin hs = 1; hsaddr = mem_addr; hsdly = dly[cur % 4]; in_req = 0; end
         end else begin
            in_req = 0;
            mem_req_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   // per-cycle compare against the model
   initial forever begin
      @(negedge clk); #1;
      if (rst_n) begin
         chk("req_ready_vs_busy", req_ready, !busy);
         chk("status_exclusive", int'(req_ready) + int'(mem_req_valid) + int'(rsp_valid) <= 1, 1);
         if (mem_req_valid) begin
            chk("mem_req_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("mem_addr", mem_addr, exp_q[0]);
            if (mem_req_ready) begin
               addr_log.push_back(mem_addr);
               if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
         end
         if (rsp_valid) begin
            chk("rsp_line", rsp_line, exp_line);
            chk("rsp_addr", rsp_addr, exp_raddr);
         end
      end
   end

   task automatic set_mem(input int l0, l1, l2, l3, d0, d1, d2, d3);
      rdy_low = '{l0, l1, l2, l3};
      dly = '{d0, d1, d2, d3};
   endtask

   task automatic start_fill(input logic [31:0] a);
      logic [31:0] base;
      base = {a[31:4], 4'b0000};
      exp_q.delete(); addr_log.delete(); reqn = 0;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(base + 32'(((int'(a[3:2]) + k) % 4) * 4));
         exp_line[32*k +: 32] = (base + 32'(k * 4)) ^ salt;
      end
      exp_raddr = base;
      @(negedge clk); req_valid = 1'b1; req_addr = a;
      for (int b = 0; b < 20 && !req_ready; b++) @(negedge clk);
      chk("req_accept", req_ready, 1);
      @(negedge clk); req_valid = 1'b0; busy = 1'b1;
   endtask

   task automatic finish_fill(input int hold, output int lat);
      int extra;
      extra = 0;
      for (int k = 0; k < 4; k++) extra += rdy_low[k] + dly[k] - 1;
      lat = 1;
      while (!rsp_valid && lat < 300) begin
         @(negedge clk); req_valid = 1'($urandom_range(0, 1)); req_addr = $urandom; lat++;
      end
      chk("rsp_valid_seen", rsp_valid, 1);
      chk("latency", lat, 9 + extra);
      last_line = rsp_line; last_raddr = rsp_addr;
      repeat (hold) begin
         chk("hold_valid", rsp_valid, 1);
         @(negedge clk); req_valid = 1'($urandom_range(0, 1));
      end
      rsp_ready = 1'b1; req_valid = 1'b1; req_addr = $urandom;
      @(negedge clk); rsp_ready = 1'b0; req_valid = 1'b0; busy = 1'b0;
      chk("idle_after_rsp", req_ready, 1);
      chk("rsp_cleared", rsp_valid, 0);
      chk("all_words_fetched", exp_q.size(), 0);
   endtask

   task automatic chk_log(input string name, input logic [31:0] a0, a1, a2, a3);
      logic [31:0] e[4];
      e = '{a0, a1, a2, a3};
      chk({name, "_count"}, addr_log.size(), 4);
      for (int k = 0; k < 4; k++) chk(name, addr_log.size() > k ? addr_log[k] : 32'hx, e[k]);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_req_ready"}, req_ready, 1);
      chk({name, "_rsp_valid"}, rsp_valid, 0);
      chk({name, "_mem_req_valid"}, mem_req_valid, 0);
      chk({name, "_mem_addr"}, mem_addr, 0);
      chk({name, "_rsp_addr"}, rsp_addr, 0);
      chk({name, "_rsp_line"}, rsp_line, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      set_mem(0, 0, 0, 0, 1, 1, 1, 1);
      @(negedge clk); #1;
      chk_reset_outputs("reset");
      @(negedge clk); rst_n = 1'b1;

      start_fill(32'h1234_5678); finish_fill(0, lat);
      chk("t1_latency", lat, 9);
      chk_log("t1_order", 32'h1234_5678, 32'h1234_567C, 32'h1234_5670, 32'h1234_5674);
      chk("t1_line", last_line, {32'h1234_567C, 32'h1234_5678, 32'h1234_5674, 32'h1234_5670});
      chk("t1_rsp_addr", last_raddr, 32'h1234_5670);

      set_mem(0, 3, 0, 0, 1, 1, 1, 1);
      start_fill(32'h0000_1000); finish_fill(0, lat);
      chk("t2_latency", lat, 12);
      chk_log("t2_order", 32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C);

      set_mem(0, 0, 0, 0, 1, 1, 1, 1);
      salt = 32'h5A5A_0F0F;
      start_fill(32'h0ABC_DE04); finish_fill(5, lat);
      chk("t3_rsp_addr", last_raddr, 32'h0ABC_DE00);

      salt = '0;
      start_fill(32'hFFFF_FFFC); finish_fill(1, lat);
      chk_log("t4_order", 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8);
      chk("t4_rsp_addr", last_raddr, 32'hFFFF_FFF0);

      set_mem(0, 0, 0, 0, 1, 1, 3, 1);
      start_fill(32'h0000_2008);
      repeat (6) @(negedge clk);
      rst_n = 1'b0; busy = 1'b0;
      #1 chk_reset_outputs("midfill_reset");
      @(negedge clk); rst_n = 1'b1; exp_q.delete();
      repeat (10) @(negedge clk);
      chk("stale_data_ignored", rsp_line, 0);
      chk("no_rsp_after_reset", rsp_valid, 0);
      set_mem(0, 0, 0, 0, 1, 1, 1, 1);
      start_fill(32'h0000_2008); finish_fill(0, lat);
      chk("t5_latency", lat, 9);

      spur_en = 1'b1;
      for (int r = 0; r < 20; r++) begin
         logic [31:0] a;
         a = $urandom; salt = $urandom;
         for (int k = 0; k < 4; k++) begin
            rdy_low[k] = $urandom_range(0, 3);
            dly[k] = $urandom_range(1, 3);
         end
         start_fill(a); finish_fill($urandom_range(0, 3), lat);
      end
      spur_en = 1'b0;
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
